// File: rtl/alu_mem_pkg.sv
// Shared definitions for the ALU/register-file pipeline with taint tracking.
package alu_mem_pkg;

  typedef enum logic [1:0] {
    OP_XOR = 2'b00,
    OP_AND = 2'b01,
    OP_OR  = 2'b10,
    OP_ADD = 2'b11
  } op_e;

endpackage

// File: rtl/alu_mem_taint_core.sv
// Combinational ALU datapath and taint-propagation rules for one instruction.
module alu_mem_taint_core
  import alu_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic [1:0]        op,
  input  logic              mode,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [DATA_W-1:0] imm,
  input  logic              rs1_t,
  input  logic              rs2_t,
  input  logic              imm_t,
  input  logic              mode_t,
  input  logic              op_t,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  input  logic              rs1_mem_t,
  input  logic              rs2_mem_t,
  output logic [DATA_W-1:0] res,
  output logic              res_t
);

  op_e               op_dec;
  logic [DATA_W-1:0] op1, op2;
  logic              op1_t, op2_t, ctl_t;

  assign op_dec = op_e'(op);
  assign op1    = rs1_data;
  assign op2    = mode ? imm : rs2_data;
  assign op1_t  = rs1_mem_t || rs1_t;
  assign op2_t  = mode ? imm_t : (rs2_mem_t || rs2_t);
  assign ctl_t  = mode_t || op_t;

  always_comb begin
    res = '0;
    unique case (op_dec)
      OP_XOR: res = op1 ^ op2;
      OP_AND: res = op1 & op2;
      OP_OR:  res = op1 | op2;
      OP_ADD: res = op1 + op2;
      default: res = '0;
    endcase
  end

  always_comb begin
    res_t = op1_t || op2_t || ctl_t;
    // x ^ x is constant zero whatever the register holds
    if (!ctl_t && !mode && !rs1_t && !rs2_t && (rs1 == rs2) && (op_dec == OP_XOR)) begin
      res_t = 1'b0;
    end
    // an untainted zero forces an AND result regardless of the other operand
    if (!ctl_t && (op_dec == OP_AND) &&
        ((!op1_t && (op1 == '0)) || (!op2_t && (op2 == '0)))) begin
      res_t = 1'b0;
    end
  end

endmodule

// File: rtl/alu_mem_pipe.sv
// Register file + one-stage result register with valid/ready handshake and taint tracking.
module alu_mem_pipe
  import alu_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic              mode,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] imm,
  input  logic              rs1_t,
  input  logic              rs2_t,
  input  logic              rd_t,
  input  logic              imm_t,
  input  logic              mode_t,
  input  logic              op_t,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              result_t,
  output logic [ADDR_W-1:0] rd_out,
  output logic [ADDR_W:0]   taint_cnt
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  mem_t_q;
  logic              out_valid_q, result_t_q;
  logic [DATA_W-1:0] result_q;
  logic [ADDR_W-1:0] rd_out_q;
  logic [ADDR_W:0]   taint_cnt_q, taint_cnt_d;
  logic [DATA_W-1:0] res;
  logic              res_t, wr_t, accept;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign wr_t     = res_t || rd_t;

  alu_mem_taint_core #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_core (
    .op       (op),
    .mode     (mode),
    .rs1      (rs1),
    .rs2      (rs2),
    .imm      (imm),
    .rs1_t    (rs1_t),
    .rs2_t    (rs2_t),
    .imm_t    (imm_t),
    .mode_t   (mode_t),
    .op_t     (op_t),
    .rs1_data (mem_q[rs1]),
    .rs2_data (mem_q[rs2]),
    .rs1_mem_t(mem_t_q[rs1]),
    .rs2_mem_t(mem_t_q[rs2]),
    .res      (res),
    .res_t    (res_t)
  );

  always_comb begin
    taint_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      taint_cnt_d = taint_cnt_d + {{ADDR_W{1'b0}}, mem_t_q[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      mem_t_q     <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_t_q  <= 1'b0;
      rd_out_q    <= '0;
      taint_cnt_q <= '0;
    end else begin
      taint_cnt_q <= taint_cnt_d;
      if (accept) begin
        mem_q[rd]   <= res;
        mem_t_q[rd] <= wr_t;
        out_valid_q <= 1'b1;
        result_q    <= res;
        result_t_q  <= wr_t;
        rd_out_q    <= rd;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_t  = result_t_q;
  assign rd_out    = rd_out_q;
  assign taint_cnt = taint_cnt_q;

endmodule

// File: tb/tb_alu_mem_pipe.sv
// Directed vector bench for alu_mem_pipe at default parameters.
module tb_alu_mem_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, mode, out_valid, out_ready, result_t;
  logic [1:0] op;
  logic [3:0] rs1, rs2, rd, rd_out;
  logic [7:0] imm, result;
  logic       rs1_t, rs2_t, rd_t, imm_t, mode_t, op_t;
  logic [4:0] taint_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_mem_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .mode     (mode),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .imm      (imm),
    .rs1_t    (rs1_t),
    .rs2_t    (rs2_t),
    .rd_t     (rd_t),
    .imm_t    (imm_t),
    .mode_t   (mode_t),
    .op_t     (op_t),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .result_t (result_t),
    .rd_out   (rd_out),
    .taint_cnt(taint_cnt)
  );

  // t = {rs1_t, rs2_t, rd_t, imm_t, mode_t, op_t}
  typedef struct {
    logic [1:0] op;
    logic       mode;
    logic [3:0] rs1, rs2, rd;
    logic [7:0] imm;
    logic [5:0] t;
    logic [7:0] exp_res;
    logic       exp_t;
    logic [4:0] exp_cnt;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic [1:0] op_i, logic mode_i, logic [3:0] a, logic [3:0] b,
                              logic [3:0] d, logic [7:0] im, logic [5:0] t,
                              logic [7:0] er, logic et, logic [4:0] ec);
    vec_t v;
    v.op = op_i; v.mode = mode_i; v.rs1 = a; v.rs2 = b; v.rd = d; v.imm = im; v.t = t;
    v.exp_res = er; v.exp_t = et; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    op = v.op; mode = v.mode; rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; imm = v.imm;
    {rs1_t, rs2_t, rd_t, imm_t, mode_t, op_t} = v.t;
    in_valid = 1'b1;
  endtask

  // Issue one instruction with out_ready high, then one idle cycle.
  task automatic apply(vec_t v, int idx);
    @(negedge clk);
    out_ready = 1'b1;
    drive(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'd1);
    chk($sformatf("v%0d result", idx), 32'(result), 32'(v.exp_res));
    chk($sformatf("v%0d result_t", idx), 32'(result_t), 32'(v.exp_t));
    chk($sformatf("v%0d rd_out", idx), 32'(rd_out), 32'(v.rd));
    chk($sformatf("v%0d mem", idx), 32'(dut.mem_q[v.rd]), 32'(v.exp_res));
    chk($sformatf("v%0d mem_t", idx), 32'(dut.mem_t_q[v.rd]), 32'(v.exp_t));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d drained", idx), 32'(out_valid), 32'd0);
    chk($sformatf("v%0d result held", idx), 32'(result), 32'(v.exp_res));
    chk($sformatf("v%0d taint_cnt", idx), 32'(taint_cnt), 32'(v.exp_cnt));
  endtask

  initial begin
    vecs[0]  = mk(2'b00, 1, 0, 0,  3, 8'hA5, 6'b000000, 8'hA5, 0, 0);
    vecs[1]  = mk(2'b11, 1, 3, 0,  4, 8'h6B, 6'b000000, 8'h10, 0, 0);
    vecs[2]  = mk(2'b00, 1, 0, 0,  5, 8'h3C, 6'b000100, 8'h3C, 1, 1);
    vecs[3]  = mk(2'b00, 0, 5, 5,  6, 8'h00, 6'b000000, 8'h00, 0, 1);
    vecs[4]  = mk(2'b01, 1, 5, 0,  7, 8'h00, 6'b000000, 8'h00, 0, 1);
    vecs[5]  = mk(2'b01, 1, 5, 0,  8, 8'h01, 6'b000000, 8'h00, 1, 2);
    vecs[6]  = mk(2'b10, 0, 3, 4,  9, 8'h00, 6'b000000, 8'hB5, 0, 2);
    vecs[7]  = mk(2'b11, 0, 9, 3, 10, 8'h00, 6'b000000, 8'h5A, 0, 2);
    vecs[8]  = mk(2'b10, 1, 3, 0, 11, 8'h00, 6'b001000, 8'hA5, 1, 3);
    vecs[9]  = mk(2'b01, 0, 4, 5, 12, 8'h00, 6'b000000, 8'h10, 1, 4);
    vecs[10] = mk(2'b00, 1, 4, 0, 13, 8'hFF, 6'b000001, 8'hEF, 1, 5);
    vecs[11] = mk(2'b01, 1, 4, 0, 14, 8'h00, 6'b000001, 8'h00, 1, 6);
    vecs[12] = mk(2'b00, 0, 3, 3, 15, 8'h00, 6'b100000, 8'h00, 1, 7);
    vecs[13] = mk(2'b11, 1, 4, 0,  4, 8'h01, 6'b000000, 8'h11, 0, 7);
    vecs[14] = mk(2'b10, 1, 4, 0,  0, 8'h00, 6'b000000, 8'h11, 0, 7);
    vecs[15] = mk(2'b01, 0, 5, 0,  1, 8'h00, 6'b000000, 8'h10, 1, 8);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; mode = 1'b0; rs1 = '0; rs2 = '0; rd = '0; imm = '0;
    {rs1_t, rs2_t, rd_t, imm_t, mode_t, op_t} = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result", 32'(result), 32'd0);
    chk("reset taint_cnt", 32'(taint_cnt), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 16; i++) apply(vecs[i], i);

    // Back-to-back: second instruction reads the register the first just wrote.
    @(negedge clk);
    drive(mk(2'b11, 1, 2, 0, 2, 8'h07, 6'b000000, 8'h07, 0, 8));
    @(posedge clk);
    #1;
    chk("b2b first", 32'(result), 32'h07);
    drive(mk(2'b11, 1, 2, 0, 2, 8'h01, 6'b000000, 8'h08, 0, 8));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("b2b second", 32'(result), 32'h08);
    chk("b2b mem", 32'(dut.mem_q[2]), 32'h08);
    @(posedge clk);
    #1;

    // Stall: result held while consumer is not ready.
    out_ready = 1'b0;
    drive(mk(2'b00, 1, 0, 0, 2, 8'h55, 6'b000000, 8'h44, 0, 8));
    @(posedge clk);
    #1;
    chk("stall first result", 32'(result), 32'h44);
    chk("stall in_ready", 32'(in_ready), 32'd0);
    drive(mk(2'b10, 1, 0, 0, 3, 8'h80, 6'b000000, 8'h91, 0, 8));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall c%0d in_ready", c), 32'(in_ready), 32'd0);
      chk($sformatf("stall c%0d result", c), 32'(result), 32'h44);
      chk($sformatf("stall c%0d rd_out", c), 32'(rd_out), 32'd2);
      chk($sformatf("stall c%0d mem3", c), 32'(dut.mem_q[3]), 32'hA5);
    end
    out_ready = 1'b1;
    #1;
    chk("release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("release out_valid", 32'(out_valid), 32'd1);
    chk("release result", 32'(result), 32'h91);
    chk("release rd_out", 32'(rd_out), 32'd3);
    chk("release mem3", 32'(dut.mem_q[3]), 32'h91);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a stall.
    out_ready = 1'b0;
    drive(mk(2'b10, 1, 0, 0, 4, 8'h00, 6'b000100, 8'h11, 1, 9));
    @(posedge clk);
    #1;
    chk("pre-reset mem_t4", 32'(dut.mem_t_q[4]), 32'd1);
    drive(mk(2'b10, 1, 0, 0, 6, 8'hF0, 6'b000000, 8'h00, 0, 0));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async out_valid", 32'(out_valid), 32'd0);
    chk("async taint_cnt", 32'(taint_cnt), 32'd0);
    chk("async result", 32'(result), 32'd0);
    chk("async mem_t", 32'(dut.mem_t_q), 32'd0);
    for (int i = 0; i < 16; i++) chk($sformatf("async mem%0d", i), 32'(dut.mem_q[i]), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post-reset in_ready", 32'(in_ready), 32'd1);
    apply(mk(2'b00, 1, 0, 0, 1, 8'h5A, 6'b000000, 8'h5A, 0, 0), 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
